simon_play_sched: RTL and testbench

//  Sequence store and playback scheduler for the Simon game. Fills an N-entry colour

---
 rtl/simon_play_sched_if.sv | 26 ++
 rtl/simon_play_sched.sv | 218 +++++++++++++++++++++
 tb/tb_simon_play_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/simon_play_sched_if.sv
// Handshake and read-port bundle between the Simon game FSM (master) and the
// sequence store / playback scheduler (slave).
interface simon_play_sched_if #(
  parameter int unsigned IDXW = 4
) ();
  logic            gen_req;
  logic            play_req;
  logic [IDXW:0]   play_len;
  logic            play_abort;
  logic            busy;
  logic            gen_done;
  logic            play_done;
  logic [3:0]      led;
  logic [IDXW-1:0] rd_idx;
  logic [1:0]      rd_val;

  modport master (
    output gen_req, play_req, play_len, play_abort, rd_idx,
    input  busy, gen_done, play_done, led, rd_val
  );

  modport slave (
    input  gen_req, play_req, play_len, play_abort, rd_idx,
    output busy, gen_done, play_done, led, rd_val
  );
endinterface

// File: rtl/simon_play_sched.sv
// Simon sequence store and playback scheduler: fills an N-entry colour memory
// from a free-running Galois LFSR, then plays the first len colours on the LEDs
// with an LED-on time that shrinks as the round grows.
// Build option: SIMON_SCHED_NO_REPEAT_EN makes GEN bump a colour that would
// repeat its predecessor, so no two adjacent stored colours match.
module simon_play_sched #(
  parameter int unsigned N       = 16,
  parameter int unsigned IDXW    = 4,
  parameter int unsigned BASE_ON = 6,
  parameter int unsigned MIN_ON  = 2,
  parameter int unsigned GAP     = 2
) (
  input logic               clk_tick,
  input logic               reset_n,
  simon_play_sched_if.slave bus
);

  localparam int unsigned CNTW      = 8;
  localparam int unsigned LENW      = IDXW + 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GEN  = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [LENW-1:0] len_q, len_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] on_t_q, on_t_d;
  logic [3:0]      led_q, led_d;
  logic            busy_q, busy_d;
  logic            gen_done_q, gen_done_d;
  logic            play_done_q, play_done_d;

  logic [1:0]      mem_q [N];
  logic            mem_we;
  logic [IDXW-1:0] mem_waddr;
  logic [1:0]      mem_wdata;

  logic [LENW-1:0] play_len_c;
  logic [CNTW-1:0] on_t_c;
  logic [CNTW-1:0] on_shr_c;
  logic [CNTW-1:0] on_diff_c;
  logic [IDXW-1:0] idx_inc_c;
  logic [1:0]      gen_wdata_c;

  // Clamp the requested length and derive the saturating LED-on time.
  always_comb begin
    play_len_c = (bus.play_len > LENW'(N)) ? LENW'(N) : bus.play_len;
    on_shr_c   = CNTW'(play_len_c >> 2);
    on_diff_c  = (CNTW'(BASE_ON) > on_shr_c) ? (CNTW'(BASE_ON) - on_shr_c) : '0;
    on_t_c     = (on_diff_c < CNTW'(MIN_ON)) ? CNTW'(MIN_ON) : on_diff_c;
    idx_inc_c  = idx_q + IDXW'(1);
  end

  // Colour written during GEN: raw LFSR bits, optionally bumped to avoid a repeat.
`ifdef SIMON_SCHED_NO_REPEAT_EN
  logic [1:0] gen_prev_c;
  always_comb begin
    gen_prev_c  = mem_q[idx_q - IDXW'(1)];
    gen_wdata_c = ((idx_q != '0) && (lfsr_q[1:0] == gen_prev_c)) ?
                  (lfsr_q[1:0] + 2'd1) : lfsr_q[1:0];
  end
`else
  always_comb begin
    gen_wdata_c = lfsr_q[1:0];
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    on_t_d      = on_t_q;
    led_d       = led_q;
    busy_d      = busy_q;
    gen_done_d  = 1'b0;
    play_done_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = idx_q;
    mem_wdata   = gen_wdata_c;

    case (state_q)
      S_IDLE: begin
        if (bus.gen_req) begin
          state_d = S_GEN;
          idx_d   = '0;
          busy_d  = 1'b1;
          led_d   = 4'b0000;
        end else if (bus.play_req) begin
          len_d  = play_len_c;
          on_t_d = on_t_c;
          idx_d  = '0;
          busy_d = 1'b1;
          if (play_len_c == '0) begin
            state_d = S_DONE;
            led_d   = 4'b0000;
          end else begin
            state_d = S_ON;
            led_d   = 4'b0001 << mem_q[0];
            cnt_d   = on_t_c - CNTW'(1);
          end
        end
      end

      S_GEN: begin
        if (bus.play_abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          mem_we = 1'b1;
          if (idx_q == IDXW'(N - 1)) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            gen_done_d = 1'b1;
          end else begin
            idx_d = idx_inc_c;
          end
        end
      end

      S_ON: begin
        if (bus.play_abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          led_d   = 4'b0000;
        end else if (cnt_q == '0) begin
          state_d = S_GAP;
          led_d   = 4'b0000;
          cnt_d   = CNTW'(GAP - 1);
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_GAP: begin
        if (bus.play_abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          led_d   = 4'b0000;
        end else if (cnt_q == '0) begin
          if ((LENW'(idx_q) + LENW'(1)) == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ON;
            idx_d   = idx_inc_c;
            led_d   = 4'b0001 << mem_q[idx_inc_c];
            cnt_d   = on_t_q - CNTW'(1);
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        led_d       = 4'b0000;
        play_done_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        led_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_tick or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      on_t_q      <= '0;
      led_q       <= 4'b0000;
      busy_q      <= 1'b0;
      gen_done_q  <= 1'b0;
      play_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      on_t_q      <= on_t_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      gen_done_q  <= gen_done_d;
      play_done_q <= play_done_d;
    end
  end

  // Colour memory: deliberately not cleared by reset.
  always_ff @(posedge clk_tick) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.gen_done  = gen_done_q;
  assign bus.play_done = play_done_q;
  assign bus.led       = led_q;
  assign bus.rd_val    = mem_q[bus.rd_idx];

endmodule

// File: tb/tb_simon_play_sched.sv
// Self-checking bench for simon_play_sched: randomized generate/play/abort
// scenarios checked cycle by cycle against a behavioural model of the game rules.
module tb_simon_play_sched;

  localparam int N       = 16;
  localparam int BASE_ON = 6;
  localparam int MIN_ON  = 2;
  localparam int GAP     = 2;
  localparam int NONE    = 1000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  simon_play_sched_if #(.IDXW(4)) bus ();

  simon_play_sched #(
    .N(16), .IDXW(4), .BASE_ON(6), .MIN_ON(2), .GAP(2)
  ) dut (
    .clk_tick (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  ref_mem [N];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  // Reference LFSR: seeded on reset, one step per tick.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_adv(m_lfsr);
  end

  function automatic int exp_on_t(input int len);
    int o;
    o = BASE_ON - len / 4;
    if (o < MIN_ON) o = MIN_ON;
    return o;
  endfunction

  task automatic idle_cycles(input int n);
    @(negedge clk);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.gen_req = 1'b0; bus.play_req = 1'b0; bus.play_len = '0;
    bus.play_abort = 1'b0; bus.rd_idx = '0;
    reset_n = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.led !== 4'b0000) begin failures++; $display("FAIL reset_led got %b exp 0000", bus.led); end
    checks++; if (bus.gen_done !== 1'b0) begin failures++; $display("FAIL reset_gen_done got %b exp 0", bus.gen_done); end
    checks++; if (bus.play_done !== 1'b0) begin failures++; $display("FAIL reset_play_done got %b exp 0", bus.play_done); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Fill the memory; optionally with play_req raised in the same cycle (gen wins).
  task automatic test_gen(input bit with_play, input string name);
    logic [15:0] v;
    logic [1:0]  raw;
    logic [1:0]  got [N];
    logic        eb, eg;
    idle_cycles($urandom_range(0, 9));
    bus.gen_req  = 1'b1;
    bus.play_req = with_play;
    bus.play_len = 5'd3;
    @(posedge clk);
    #1 v = m_lfsr;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      eb = (j < N);
      eg = (j == N);
      checks++; if (bus.busy !== eb) begin failures++; $display("FAIL %s busy j=%0d got %b exp %b", name, j, bus.busy, eb); end
      checks++; if (bus.gen_done !== eg) begin failures++; $display("FAIL %s gen_done j=%0d got %b exp %b", name, j, bus.gen_done, eg); end
      checks++; if (bus.led !== 4'b0000 || bus.play_done !== 1'b0) begin
        failures++; $display("FAIL %s no_play j=%0d led got %b play_done got %b exp 0000/0", name, j, bus.led, bus.play_done);
      end
      if (j == 0) begin bus.gen_req = 1'b0; bus.play_req = 1'b0; end
    end
    for (int k = 0; k < N; k++) begin
      raw = v[1:0];
`ifdef SIMON_SCHED_NO_REPEAT_EN
      if (k > 0 && raw == ref_mem[k-1]) raw = raw + 2'd1;
`endif
      ref_mem[k] = raw;
      v = lfsr_adv(v);
    end
    for (int k = 0; k < N; k++) begin
      bus.rd_idx = 4'(k);
      #1;
      got[k] = bus.rd_val;
      checks++; if (bus.rd_val !== ref_mem[k]) begin failures++; $display("FAIL %s mem[%0d] got %0d exp %0d", name, k, bus.rd_val, ref_mem[k]); end
    end
`ifdef SIMON_SCHED_NO_REPEAT_EN
    for (int k = 1; k < N; k++) begin
      checks++; if (got[k] === got[k-1]) begin failures++; $display("FAIL %s no_repeat k=%0d got %0d exp not %0d", name, k, got[k], got[k-1]); end
    end
`endif
  endtask

  // Play a round, comparing led/busy/play_done every cycle against the model.
  // req_j: cycle at which gen_req/play_req are raised (must be ignored).
  // abort_j: cycle at which play_abort is raised for one cycle.
  task automatic play_run(input int plen, input bit abort_at_accept,
                          input int req_j, input int abort_j, input string name);
    int L, ot, per, total, c, p;
    bit aborted;
    logic [3:0] eled;
    logic eb, ed;
    L = (plen > N) ? N : plen;
    ot = exp_on_t(L);
    per = ot + GAP;
    total = L * per;
    aborted = 1'b0;
    idle_cycles($urandom_range(0, 3));
    bus.play_req   = 1'b1;
    bus.play_len   = 5'(plen);
    bus.play_abort = abort_at_accept;
    for (int j = 0; j <= total + 2; j++) begin
      @(negedge clk);
      if (j == abort_j + 1) aborted = 1'b1;
      c = j / per;
      p = j % per;
      if (aborted) begin
        eled = 4'b0000; eb = 1'b0; ed = 1'b0;
      end else begin
        eled = (c < L && p < ot) ? (4'b0001 << ref_mem[c]) : 4'b0000;
        eb = (j <= total);
        ed = (j == total + 1);
      end
      checks++; if (bus.led !== eled) begin failures++; $display("FAIL %s led j=%0d got %b exp %b", name, j, bus.led, eled); end
      checks++; if (bus.busy !== eb) begin failures++; $display("FAIL %s busy j=%0d got %b exp %b", name, j, bus.busy, eb); end
      checks++; if (bus.play_done !== ed) begin failures++; $display("FAIL %s play_done j=%0d got %b exp %b", name, j, bus.play_done, ed); end
      if (j == 0) begin bus.play_req = 1'b0; bus.play_abort = 1'b0; bus.play_len = 5'($urandom_range(0, 31)); end
      if (j == req_j) begin bus.play_req = 1'b1; bus.gen_req = 1'b1; bus.play_len = 5'd7; end
      if (j == req_j + 2) begin bus.play_req = 1'b0; bus.gen_req = 1'b0; end
      if (j == abort_j) bus.play_abort = 1'b1;
      if (j == abort_j + 1) bus.play_abort = 1'b0;
    end
  endtask

  task automatic test_reset_mid_gap();
    idle_cycles(1);
    bus.play_req = 1'b1;
    bus.play_len = 5'd3;
    repeat (7) @(negedge clk);
    bus.play_req = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.led !== 4'b0000) begin
      failures++; $display("FAIL rst_gap_pre busy/led got %b/%b exp 1/0000", bus.busy, bus.led);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_gap_busy got %b exp 0", bus.busy); end
    checks++; if (bus.led !== 4'b0000) begin failures++; $display("FAIL rst_gap_led got %b exp 0000", bus.led); end
    checks++; if (bus.play_done !== 1'b0 || bus.gen_done !== 1'b0) begin
      failures++; $display("FAIL rst_gap_done got %b/%b exp 0/0", bus.play_done, bus.gen_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) test_gen(1'b0, "rand_gen");
      play_run($urandom_range(0, 20), 1'($urandom_range(0, 1)), NONE, NONE, "rand_play");
    end
  endtask

  initial begin
    test_reset();
    test_gen(1'b0, "gen");
    play_run(3, 1'b0, NONE, NONE, "play_len3");
    play_run(16, 1'b0, NONE, NONE, "play_len16");
    play_run(20, 1'b0, NONE, NONE, "play_clamp20");
    play_run(0, 1'b0, NONE, NONE, "play_len0");
    test_gen(1'b1, "gen_and_play");
    play_run(3, 1'b0, 2, NONE, "req_during_on");
    play_run(3, 1'b0, NONE, 9, "abort_on2");
    play_run(5, 1'b0, NONE, 7, "abort_gap");
    test_random();
    test_reset_mid_gap();
    play_run(2, 1'b0, NONE, NONE, "mem_kept");
    test_gen(1'b0, "gen_reseed");
    play_run(9, 1'b0, NONE, NONE, "play_len9");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
